// File: rtl/stage5_ctrl_pkg.sv
// Purpose: shared encodings for the stage-5 control sequencer (opcodes, states, mux selects).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage5_ctrl_pkg;

  // Opcode field IR[15:12]
  localparam logic [3:0] OP_PUSHI = 4'd0;
  localparam logic [3:0] OP_ALU   = 4'd1;
  localparam logic [3:0] OP_JUMP  = 4'd2;
  localparam logic [3:0] OP_BZ    = 4'd3;
  localparam logic [3:0] OP_CALL  = 4'd4;
  localparam logic [3:0] OP_RET   = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd7;

  // Memory port address / data selects
  localparam logic [1:0] MEMDST1_PC   = 2'd0;
  localparam logic [1:0] MEMDST2_MSP  = 2'd0;
  localparam logic [1:0] MEMDST2_RSP  = 2'd1;
  localparam logic [2:0] MEMDATA_PC   = 3'd0;
  localparam logic [2:0] MEMDATA_RES  = 3'd1;
  localparam logic [2:0] MEMDATA_IMM  = 3'd2;

  // PC and stack pointer direction selects
  localparam logic PCSRC_ADDER = 1'b0;
  localparam logic PCSRC_VALA  = 1'b1;
  localparam logic PCADD_ONE   = 1'b0;
  localparam logic PCADD_SEXT  = 1'b1;
  localparam logic MSP_INC     = 1'b0;
  localparam logic MSP_DEC     = 1'b1;
  localparam logic RSP_DEC     = 1'b0;
  localparam logic RSP_INC     = 1'b1;

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_PSH_IMM,
    S_POPB_DEC, S_POPB_RD, S_POPA_DEC, S_POPA_RD, S_EXE, S_PSH_RES,
    S_JMP, S_BR_TEST, S_RS_DEC, S_RS_WR, S_BR_TAKE, S_RS_RD, S_RS_INC,
    S_HALT
  } state_t;

  // Which instruction owns the shared POPA_* / JMP states
  typedef enum logic [1:0] {CTX_ALU, CTX_JUMP, CTX_BZ, CTX_RET} ctx_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcSource;
    logic       pcAdd;
    logic       mspWrite;
    logic       mspPop;
    logic       rspWrite;
    logic       rspPop;
    logic       valAWrite;
    logic       valBWrite;
    logic       irWrite;
    logic       memRead1;
    logic       memRead2;
    logic       memWrite1;
    logic       memWrite2;
    logic [1:0] memDst1;
    logic [1:0] memDst2;
    logic [2:0] memData;
    logic [2:0] aluOp;
    logic       resWrite;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  function automatic logic isIllegal(input logic [3:0] op);
    return (op == 4'd6) || (op > OP_HALT);
  endfunction

endpackage

// File: rtl/stage5_control_fsm_if.sv
// Purpose: control bundle between the stage-5 sequencer (master) and datapath (slave).
// Latency: n/a (wires only).
// Backpressure: none; the datapath obeys strobes unconditionally.
// Ports: IROut/ValAOut flow datapath->sequencer, every strobe/select flows sequencer->datapath.
interface stage5_control_fsm_if;
  logic [15:0] IROut;
  logic [15:0] ValAOut;
  logic        PCWrite, PCSource, PCAdd;
  logic        MSPWrite, MSPPop;
  logic        RSPWrite, RSPPop;
  logic        ValAWrite, ValBWrite, IRWrite;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0]  MemDst1, MemDst2;
  logic [2:0]  MemData;
  logic [2:0]  ALUOp;
  logic        ResWrite, Halted, Illegal;

  modport master (
    input  IROut, ValAOut,
    output PCWrite, PCSource, PCAdd, MSPWrite, MSPPop, RSPWrite, RSPPop,
           ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
           MemDst1, MemDst2, MemData, ALUOp, ResWrite, Halted, Illegal
  );

  modport slave (
    output IROut, ValAOut,
    input  PCWrite, PCSource, PCAdd, MSPWrite, MSPPop, RSPWrite, RSPPop,
           ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
           MemDst1, MemDst2, MemData, ALUOp, ResWrite, Halted, Illegal
  );
endinterface

// File: rtl/stage5_ctrl_decode.sv
// Purpose: combinational state-to-strobe decoder for the stage-5 sequencer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: state/opcode/aluSel/valAZero in, ctrl (all datapath strobes and selects) out.
module stage5_ctrl_decode
  import stage5_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic [2:0] aluSel,
  input  logic       valAZero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead1 = 1'b1;
        ctrl.memDst1  = MEMDST1_PC;
        ctrl.irWrite  = 1'b1;
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_ADDER;
        ctrl.pcAdd    = PCADD_ONE;
      end
      S_DECODE: ctrl.illegal = isIllegal(opcode);
      S_PSH_IMM: begin
        ctrl.memWrite2 = 1'b1;
        ctrl.memDst2   = MEMDST2_MSP;
        ctrl.memData   = MEMDATA_IMM;
        ctrl.mspWrite  = 1'b1;
        ctrl.mspPop    = MSP_INC;
      end
      // Main stack pop: pointer moves down first, then the slot is read
      S_POPB_DEC, S_POPA_DEC: begin
        ctrl.mspWrite = 1'b1;
        ctrl.mspPop   = MSP_DEC;
      end
      S_POPB_RD: begin
        ctrl.memRead2  = 1'b1;
        ctrl.memDst2   = MEMDST2_MSP;
        ctrl.valBWrite = 1'b1;
      end
      S_POPA_RD: begin
        ctrl.memRead2  = 1'b1;
        ctrl.memDst2   = MEMDST2_MSP;
        ctrl.valAWrite = 1'b1;
      end
      S_EXE: begin
        ctrl.aluOp    = aluSel;
        ctrl.resWrite = 1'b1;
      end
      S_PSH_RES: begin
        ctrl.memWrite2 = 1'b1;
        ctrl.memDst2   = MEMDST2_MSP;
        ctrl.memData   = MEMDATA_RES;
        ctrl.mspWrite  = 1'b1;
        ctrl.mspPop    = MSP_INC;
      end
      S_JMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_VALA;
      end
      // Branch taken only when the popped value is zero; otherwise a dead cycle
      S_BR_TEST: begin
        ctrl.pcWrite  = valAZero;
        ctrl.pcSource = PCSRC_ADDER;
        ctrl.pcAdd    = valAZero ? PCADD_SEXT : PCADD_ONE;
      end
      S_RS_DEC: begin
        ctrl.rspWrite = 1'b1;
        ctrl.rspPop   = RSP_DEC;
      end
      S_RS_WR: begin
        ctrl.memWrite2 = 1'b1;
        ctrl.memDst2   = MEMDST2_RSP;
        ctrl.memData   = MEMDATA_PC;
      end
      S_BR_TAKE: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_ADDER;
        ctrl.pcAdd    = PCADD_SEXT;
      end
      S_RS_RD: begin
        ctrl.memRead2  = 1'b1;
        ctrl.memDst2   = MEMDST2_RSP;
        ctrl.valAWrite = 1'b1;
      end
      S_RS_INC: begin
        ctrl.rspWrite = 1'b1;
        ctrl.rspPop   = RSP_INC;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/stage5_control_fsm.sv
// Purpose: multi-cycle Moore sequencer issuing all stage-5 datapath strobes.
// Latency: 2-8 cycles per instruction; outputs decoded from the current state.
// Backpressure: none; HALT absorbs until Reset.
// Ports: CLK, Reset (sync, active-high), ctl (master side of stage5_control_fsm_if).
module stage5_control_fsm
  import stage5_ctrl_pkg::*;
(
  input logic                  CLK,
  input logic                  Reset,
  stage5_control_fsm_if.master ctl
);

  state_t     state;
  ctx_t       ctx;
  ctrl_t      decoded;
  ctrl_t      ctrl;
  logic [3:0] opcode;
  logic       unusedIrBits;

  assign opcode       = ctl.IROut[15:12];
  assign unusedIrBits = ^ctl.IROut[11:3];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
      ctx   <= CTX_ALU;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_PUSHI: state <= S_PSH_IMM;
            OP_ALU:   begin state <= S_POPB_DEC; ctx <= CTX_ALU;  end
            OP_JUMP:  begin state <= S_POPA_DEC; ctx <= CTX_JUMP; end
            OP_BZ:    begin state <= S_POPA_DEC; ctx <= CTX_BZ;   end
            OP_CALL:  state <= S_RS_DEC;
            OP_RET:   begin state <= S_RS_RD;    ctx <= CTX_RET;  end
            OP_HALT:  state <= S_HALT;
            default:  state <= S_FETCH;  // undefined opcode behaves as NOP
          endcase
        end
        S_POPB_DEC: state <= S_POPB_RD;
        S_POPB_RD:  state <= S_POPA_DEC;
        S_POPA_DEC: state <= S_POPA_RD;
        S_POPA_RD: begin
          case (ctx)
            CTX_JUMP: state <= S_JMP;
            CTX_BZ:   state <= S_BR_TEST;
            default:  state <= S_EXE;
          endcase
        end
        S_EXE:    state <= S_PSH_RES;
        S_RS_DEC: state <= S_RS_WR;
        S_RS_WR:  state <= S_BR_TAKE;
        S_RS_RD:  state <= S_RS_INC;
        S_RS_INC: state <= S_JMP;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;  // PSH_IMM, PSH_RES, JMP, BR_TEST, BR_TAKE
      endcase
    end
  end

  stage5_ctrl_decode uDecode (
    .state    (state),
    .opcode   (opcode),
    .aluSel   (ctl.IROut[2:0]),
    .valAZero (ctl.ValAOut == 16'd0),
    .ctrl     (decoded)
  );

  // Reset blanks the strobes in the very cycle it is asserted so an
  // abandoned instruction cannot commit a partial step.
  assign ctrl = Reset ? '0 : decoded;

  assign ctl.PCWrite   = ctrl.pcWrite;
  assign ctl.PCSource  = ctrl.pcSource;
  assign ctl.PCAdd     = ctrl.pcAdd;
  assign ctl.MSPWrite  = ctrl.mspWrite;
  assign ctl.MSPPop    = ctrl.mspPop;
  assign ctl.RSPWrite  = ctrl.rspWrite;
  assign ctl.RSPPop    = ctrl.rspPop;
  assign ctl.ValAWrite = ctrl.valAWrite;
  assign ctl.ValBWrite = ctrl.valBWrite;
  assign ctl.IRWrite   = ctrl.irWrite;
  assign ctl.MemRead1  = ctrl.memRead1;
  assign ctl.MemRead2  = ctrl.memRead2;
  assign ctl.MemWrite1 = ctrl.memWrite1;
  assign ctl.MemWrite2 = ctrl.memWrite2;
  assign ctl.MemDst1   = ctrl.memDst1;
  assign ctl.MemDst2   = ctrl.memDst2;
  assign ctl.MemData   = ctrl.memData;
  assign ctl.ALUOp     = ctrl.aluOp;
  assign ctl.ResWrite  = ctrl.resWrite;
  assign ctl.Halted    = ctrl.halted;
  assign ctl.Illegal   = ctrl.illegal;

endmodule

// File: tb/tb_stage5_control_fsm.sv
module tb_stage5_control_fsm;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  stage5_control_fsm_if dp();
  stage5_control_fsm dut (.CLK(CLK), .Reset(Reset), .ctl(dp));

  typedef struct packed {
    logic pcWrite, pcSource, pcAdd, mspWrite, mspPop, rspWrite, rspPop;
    logic valAWrite, valBWrite, irWrite, memRead1, memRead2, memWrite1, memWrite2;
    logic [1:0] memDst1, memDst2;
    logic [2:0] memData, aluOp;
    logic resWrite, halted, illegal;
  } outv_t;

  int checks = 0;
  int errors = 0;

  outv_t       q[$];          // expected output per remaining cycle of current instruction
  logic [15:0] dirIr[$];
  logic [15:0] dirA[$];
  bit          idlePend = 0, halted = 0, curHalt = 0, randomMode = 0, inInstr = 0;
  int          stepIdx = 0, sinceRst = 0, haltCnt = 0, rstLeft = 0;
  logic [15:0] curIr = 16'h0, curA = 16'h0;

  function automatic outv_t sample();
    outv_t v;
    v.pcWrite = dp.PCWrite;   v.pcSource = dp.PCSource; v.pcAdd = dp.PCAdd;
    v.mspWrite = dp.MSPWrite; v.mspPop = dp.MSPPop;
    v.rspWrite = dp.RSPWrite; v.rspPop = dp.RSPPop;
    v.valAWrite = dp.ValAWrite; v.valBWrite = dp.ValBWrite; v.irWrite = dp.IRWrite;
    v.memRead1 = dp.MemRead1; v.memRead2 = dp.MemRead2;
    v.memWrite1 = dp.MemWrite1; v.memWrite2 = dp.MemWrite2;
    v.memDst1 = dp.MemDst1; v.memDst2 = dp.MemDst2; v.memData = dp.MemData;
    v.aluOp = dp.ALUOp; v.resWrite = dp.ResWrite; v.halted = dp.Halted; v.illegal = dp.Illegal;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] req);
    checks++;
    if (actual !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, actual, req, $time);
    end
  endtask

  // Cycles per instruction including FETCH and DECODE
  function automatic int expLen(input logic [3:0] op);
    case (op)
      4'd0: return 3;
      4'd1: return 8;
      4'd2, 4'd3, 4'd4, 4'd5: return 5;
      default: return 2;
    endcase
  endfunction

  // Stack pop onto ValA or ValB: pointer step then read
  task automatic pushPop(input bit toA);
    outv_t v;
    v = '0; v.mspWrite = 1'b1; v.mspPop = 1'b1; q.push_back(v);
    v = '0; v.memRead2 = 1'b1;
    if (toA) v.valAWrite = 1'b1; else v.valBWrite = 1'b1;
    q.push_back(v);
  endtask

  task automatic jumpToA();
    outv_t v;
    v = '0; v.pcWrite = 1'b1; v.pcSource = 1'b1; q.push_back(v);
  endtask

  task automatic expand(input logic [15:0] ir, input logic [15:0] a);
    outv_t v;
    logic [3:0] op;
    op = ir[15:12];
    v = '0; v.memRead1 = 1'b1; v.irWrite = 1'b1; v.pcWrite = 1'b1; q.push_back(v);
    v = '0; v.illegal = (op == 4'd6) || (op > 4'd7); q.push_back(v);
    case (op)
      4'd0: begin
        v = '0; v.memWrite2 = 1'b1; v.memData = 3'd2; v.mspWrite = 1'b1; q.push_back(v);
      end
      4'd1: begin
        pushPop(1'b0);
        pushPop(1'b1);
        v = '0; v.aluOp = ir[2:0]; v.resWrite = 1'b1; q.push_back(v);
        v = '0; v.memWrite2 = 1'b1; v.memData = 3'd1; v.mspWrite = 1'b1; q.push_back(v);
      end
      4'd2: begin pushPop(1'b1); jumpToA(); end
      4'd3: begin
        pushPop(1'b1);
        v = '0;
        if (a == 16'd0) begin v.pcWrite = 1'b1; v.pcAdd = 1'b1; end
        q.push_back(v);
      end
      4'd4: begin
        v = '0; v.rspWrite = 1'b1; q.push_back(v);
        v = '0; v.memWrite2 = 1'b1; v.memDst2 = 2'd1; q.push_back(v);
        v = '0; v.pcWrite = 1'b1; v.pcAdd = 1'b1; q.push_back(v);
      end
      4'd5: begin
        v = '0; v.memRead2 = 1'b1; v.memDst2 = 2'd1; v.valAWrite = 1'b1; q.push_back(v);
        v = '0; v.rspWrite = 1'b1; v.rspPop = 1'b1; q.push_back(v);
        jumpToA();
      end
      4'd7: curHalt = 1;
      default: ;
    endcase
  endtask

  task automatic pickInstr(output logic [15:0] ir, output logic [15:0] a);
    logic [3:0] op;
    if (dirIr.size() > 0) begin
      ir = dirIr.pop_front();
      a  = dirA.pop_front();
    end else if (randomMode) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd7 && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 5));
      ir = {op, 12'($urandom)};
      a  = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom);
    end else begin
      ir = 16'h0005;
      a  = 16'h0000;
    end
  endtask

  task automatic doCycle(input bit rst);
    outv_t exp, act;
    logic [15:0] ir, a;
    Reset = rst;
    inInstr = 0;
    if (rst) begin
      q.delete();
      idlePend = 1; halted = 0; curHalt = 0; sinceRst = 0; haltCnt = 0;
      exp = '0;
      dp.IROut = 16'($urandom);
      dp.ValAOut = 16'($urandom);
    end else begin
      sinceRst++;
      if (idlePend) begin
        idlePend = 0;
        exp = '0;
      end else begin
        if (q.size() == 0 && curHalt) begin halted = 1; curHalt = 0; end
        if (halted) begin
          exp = '0; exp.halted = 1'b1;
          haltCnt++;
        end else begin
          if (q.size() == 0) begin
            pickInstr(ir, a);
            curIr = ir; curA = a; stepIdx = 0;
            dp.IROut = ir; dp.ValAOut = a;
            expand(ir, a);
            check("seqLen", q.size(), expLen(ir[15:12]));
          end else begin
            stepIdx++;
          end
          inInstr = 1;
          exp = q.pop_front();
        end
      end
    end

    @(negedge CLK);
    act = sample();
    check("outputs", 32'(act), 32'(exp));

    // Hand-computed spot values
    if (!rst && sinceRst == 1)
      check("idleAfterReset", 32'(act), 32'd0);
    if (!rst && sinceRst == 2)
      check("fetchAfterReset", {29'd0, act.memRead1, act.irWrite, act.pcWrite}, 32'b111);
    if (inInstr && curIr == 16'h0005 && stepIdx == 2)
      check("pushiStep", {25'd0, act.memWrite2, act.memData, act.mspWrite, act.mspPop, act.irWrite},
            {25'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0});
    if (inInstr && curIr == 16'h1003 && stepIdx == 6)
      check("aluExe", {28'd0, act.aluOp, act.resWrite}, {28'd0, 3'd3, 1'b1});
    if (inInstr && curIr == 16'h3004 && stepIdx == 4)
      check("bzTest", {30'd0, act.pcWrite, act.pcAdd}, (curA == 16'd0) ? 32'b11 : 32'b00);
    if (inInstr && curIr == 16'h6000 && stepIdx == 1)
      check("illegalPulse", {31'd0, act.illegal}, 32'd1);
    if (halted && haltCnt == 20)
      check("haltedStays", {31'd0, act.halted}, 32'd1);

    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    dp.IROut = 16'h0;
    dp.ValAOut = 16'h0;

    for (int i = 0; i < 3; i++) doCycle(1'b1);

    dirIr = '{16'h0005, 16'h1003, 16'h3004, 16'h3004, 16'h4010, 16'h5000, 16'h6000, 16'h2000};
    dirA  = '{16'h1234, 16'h5555, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF};
    for (int i = 0; i < 200 && (dirIr.size() > 0 || q.size() > 0); i++) doCycle(1'b0);

    randomMode = 1;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = 0;
      if (rstLeft > 0) begin
        r = 1; rstLeft--;
      end else if (halted && haltCnt >= 4) begin
        r = 1; rstLeft = $urandom_range(0, 2);
      end else if ($urandom_range(0, 59) == 0) begin
        r = 1; rstLeft = $urandom_range(0, 2);
      end
      doCycle(r);
    end
    randomMode = 0;
    for (int i = 0; i < 3; i++) doCycle(1'b1);

    dirIr.push_back(16'h7000);
    dirA.push_back(16'h0000);
    for (int i = 0; i < 24; i++) doCycle(1'b0);
    check("haltReached", {31'd0, halted}, 32'd1);

    doCycle(1'b1);
    for (int i = 0; i < 5; i++) doCycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage5_control_fsm.md
# stage5_control_fsm

Multi-cycle control sequencer driving the stage-5 datapath integration (PC, main stack pointer MSP, return stack pointer RSP, dual-port memory access, ValA/ValB/IR registers). It reads the latched instruction and ValA, and issues every strobe and mux select the datapath consumes, one Moore state per micro-step. Opcode is IR[15:12]; immediates/offsets come from the datapath's sign/zero extenders.

## Interface
Parameters: none (encodings fixed in package).
- CLK  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- IROut  in  16  latched instruction
- ValAOut  in  16  ValA register, used for BZ test
- PCWrite, PCSource, PCAdd  out  1 each  PC control (PCSource 0 = adder, 1 = ValA; PCAdd 0 = +1, 1 = +SignExt)
- MSPWrite, MSPPop  out  1 each  MSPPop 1 = decrement, 0 = increment
- RSPWrite, RSPPop  out  1 each  RSPPop 0 = decrement (push), 1 = increment (pop)
- ValAWrite, ValBWrite, IRWrite  out  1 each  register loads
- MemRead1, MemRead2, MemWrite1, MemWrite2  out  1 each  port strobes
- MemDst1  out  2  0 = PC, 1 = MSP
- MemDst2  out  2  0 = MSP, 1 = RSP
- MemData  out  3  0 = PC, 1 = Res, 2 = ZE imm
- ALUOp  out  3  IR[2:0] during ALU state, else 0
- ResWrite  out  1  latch ALU result
- Halted  out  1  high in HALT
- Illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- Outputs purely decoded from state (Moore); any strobe not listed for a state is 0, selects 0.
- Memory read data valid within the cycle MemRead is asserted; load strobe in same state captures it.
- Main stack: MSP = next free slot (push = write then increment; pop = decrement then read). Return stack: RSP = top element, grows down (push = decrement then write; pop = read then increment).
- IDLE: all outputs 0 -> FETCH.
- FETCH: MemRead1, MemDst1=0, IRWrite, PCWrite (PCSource 0, PCAdd 0) -> DECODE.
- DECODE: no strobes; dispatch on IR[15:12]:
  - 0 PUSHI: PSH_IMM (MemWrite2, MemDst2=0, MemData=2, MSPWrite, MSPPop=0) -> FETCH.
  - 1 ALU: POPB_DEC (MSPWrite, MSPPop=1), POPB_RD (MemRead2, MemDst2=0, ValBWrite), POPA_DEC, POPA_RD (ValAWrite), EXE (ALUOp, ResWrite), PSH_RES (MemWrite2, MemData=1, MSPWrite, MSPPop=0) -> FETCH. Result = ValA op ValB.
  - 2 JUMP: POPA_DEC, POPA_RD, JMP (PCWrite, PCSource=1) -> FETCH.
  - 3 BZ: POPA_DEC, POPA_RD, BR_TEST: if ValAOut == 0 assert PCWrite, PCSource=0, PCAdd=1; else nothing -> FETCH.
  - 4 CALL: RS_DEC (RSPWrite, RSPPop=0), RS_WR (MemWrite2, MemDst2=1, MemData=0), BR_TAKE (PCWrite, PCAdd=1) -> FETCH.
  - 5 RET: RS_RD (MemRead2, MemDst2=1, ValAWrite), RS_INC (RSPWrite, RSPPop=1), JMP -> FETCH.
  - 7 HALT: HALT, Halted=1, absorbing until Reset.
  - 6, 8-15: Illegal=1 in DECODE cycle, -> FETCH (NOP).
- Shared states (POPA_*, JMP) carry a return context register so successor depends on opcode.

## Timing
- Reset: state IDLE that cycle and next; all outputs 0, Halted 0, Illegal 0.
- First FETCH strobes in 2nd cycle after Reset deasserts.
- Cycles per instruction incl. FETCH+DECODE: PUSHI 3, ALU 8, JUMP 5, BZ 5 (taken or not), CALL 5, RET 5, illegal 2.
- Branch/call offsets relative to already-incremented PC.
- Reset mid-instruction: abandon immediately, no partial strobes in the following cycle; stack pointers retain whatever already committed.
- Never assert MemWrite and MemRead on the same port in one state; never PCWrite with IRWrite except FETCH.

## Structure
- Package stage5_ctrl_pkg: opcode constants, state enum, MemDst1/MemDst2/MemData/PC select encodings.
- Sub-module stage5_ctrl_decode: combinational state-to-output decoder; FSM register/next-state in top.

## Test plan
- Reset held 3 cycles then released: all outputs 0 through first post-reset cycle; FETCH strobes (MemRead1, IRWrite, PCWrite) in 2nd.
- IR=0x0005 (PUSHI 5): 3-cycle sequence, PSH_IMM shows MemWrite2=1, MemData=2, MSPWrite=1, MSPPop=0.
- IR=0x1003 (ALU op 3): 8 cycles, ValBWrite before ValAWrite, ALUOp=3 only in EXE, PSH_RES MemData=1.
- IR=0x3004 (BZ) with ValAOut=0 -> PCWrite, PCAdd=1 in BR_TEST; with ValAOut=0x0001 -> no PCWrite.
- IR=0x4010 then 0x5000: CALL shows RSPPop=0 decrement before RS_WR MemDst2=1 MemData=0; RET reads RSP before RSPPop=1 increment, JMP PCSource=1.
- IR=0x6000 -> Illegal single pulse, back to FETCH; IR=0x7000 -> Halted stays 1 for 20 cycles, Reset returns to IDLE.
